// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: shared widths, coin values and FSM states for the change dispenser
package change_dispenser_pkg;
  localparam int kNumCoins = 3;
  localparam int kTotalBits = 16;
  localparam int kStockBits = 8;
  localparam logic [kTotalBits-1:0] kCoin100 = 16'd100;
  localparam logic [kTotalBits-1:0] kCoin500 = 16'd500;
  localparam logic [kTotalBits-1:0] kCoin1000 = 16'd1000;
  typedef enum logic [1:0] {IDLE, DISPENSE, DONE} state_e;
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: balance/timer inputs and coin/stock outputs of the change dispenser
interface change_dispenser_if;
  import change_dispenser_pkg::*;
  logic [kTotalBits-1:0] current_total;
  logic [31:0] wait_time;
  logic i_trigger_return;
  logic i_refill;
  logic [kNumCoins-1:0] o_return_coin;
  logic [kTotalBits-1:0] o_return_value;
  logic o_busy;
  logic o_done;
  logic o_shortfall;
  logic [kTotalBits-1:0] o_unpaid;
  logic [kStockBits-1:0] o_stock_1000;
  logic [kStockBits-1:0] o_stock_500;
  logic [kStockBits-1:0] o_stock_100;
  modport master (
    output current_total, wait_time, i_trigger_return, i_refill,
    input o_return_coin, o_return_value, o_busy, o_done, o_shortfall, o_unpaid,
    input o_stock_1000, o_stock_500, o_stock_100
  );
  modport slave (
    input current_total, wait_time, i_trigger_return, i_refill,
    output o_return_coin, o_return_value, o_busy, o_done, o_shortfall, o_unpaid,
    output o_stock_1000, o_stock_500, o_stock_100
  );
endinterface

// File: rtl/change_dispenser_coin_select.sv
// change_dispenser_coin_select: greedy pick of the largest in-stock coin not exceeding the remainder
module change_dispenser_coin_select
  import change_dispenser_pkg::*;
(
  input  logic [kTotalBits-1:0] remaining,
  input  logic                  has_1000,
  input  logic                  has_500,
  input  logic                  has_100,
  output logic [kNumCoins-1:0]  coin,
  output logic [kTotalBits-1:0] value
);
  always_comb begin
    coin = (has_1000 && remaining >= kCoin1000) ? 3'b100 :
           (has_500 && remaining >= kCoin500)   ? 3'b010 :
           (has_100 && remaining >= kCoin100)   ? 3'b001 : 3'b000;
    value = coin[2] ? kCoin1000 : coin[1] ? kCoin500 : coin[0] ? kCoin100 : '0;
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays the balance back one coin per cycle, largest first, within coin stock
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int kStock1000 = 8,
  parameter int kStock500  = 8,
  parameter int kStock100  = 16
) (
  input logic clk,
  input logic reset_n,
  change_dispenser_if.slave bus
);
  localparam logic [kStockBits-1:0] kInit1000 = kStockBits'(kStock1000);
  localparam logic [kStockBits-1:0] kInit500 = kStockBits'(kStock500);
  localparam logic [kStockBits-1:0] kInit100 = kStockBits'(kStock100);
  localparam logic [kStockBits-1:0] kOne = kStockBits'(1);
  state_e state, next_state;
  logic [kTotalBits-1:0] remaining;
  logic [kNumCoins-1:0] coin;
  logic [kTotalBits-1:0] value;
  logic start;
  change_dispenser_coin_select u_sel (
    .remaining(remaining),
    .has_1000 (bus.o_stock_1000 != '0),
    .has_500  (bus.o_stock_500 != '0),
    .has_100  (bus.o_stock_100 != '0),
    .coin     (coin),
    .value    (value)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  // DONE lasts two cycles: one to raise o_done, one with o_done visible before leaving
  always_comb begin
    start = (bus.wait_time == '0 || bus.i_trigger_return) && bus.current_total != '0;
    next_state = state == IDLE     ? ((start && !bus.i_refill) ? DISPENSE : IDLE) :
                 state == DISPENSE ? ((coin == '0) ? DONE : DISPENSE) :
                 (bus.o_done ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      remaining <= '0;
      bus.o_return_coin <= '0;
      bus.o_return_value <= '0;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
      bus.o_shortfall <= 1'b0;
      bus.o_unpaid <= '0;
      bus.o_stock_1000 <= kInit1000;
      bus.o_stock_500 <= kInit500;
      bus.o_stock_100 <= kInit100;
    end else begin
      bus.o_return_coin <= '0;
      bus.o_return_value <= '0;
      bus.o_busy <= next_state == DISPENSE;
      bus.o_done <= state == DONE && !bus.o_done;
      if (state == IDLE) begin
        if (bus.i_refill) begin
          bus.o_stock_1000 <= kInit1000;
          bus.o_stock_500 <= kInit500;
          bus.o_stock_100 <= kInit100;
        end else if (start) begin
          remaining <= bus.current_total;
          bus.o_shortfall <= 1'b0;
          bus.o_unpaid <= '0;
        end
      end
      if (state == DISPENSE) begin
        if (coin != '0) begin
          bus.o_return_coin <= coin;
          bus.o_return_value <= value;
          remaining <= remaining - value;
          if (coin[2]) bus.o_stock_1000 <= bus.o_stock_1000 - kOne;
          if (coin[1]) bus.o_stock_500 <= bus.o_stock_500 - kOne;
          if (coin[0]) bus.o_stock_100 <= bus.o_stock_100 - kOne;
        end else if (remaining != '0) begin
          bus.o_shortfall <= 1'b1;
          bus.o_unpaid <= remaining;
        end
      end
    end
  end
endmodule
